// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_pkg                                                             |
// | Opcodes, result width and the buffered result record of the ALU.   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package alu_pkg;

    localparam int DATA_W = 4;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef struct packed {
        logic [1:0]        op;
        logic [DATA_W-1:0] data;
        logic              zero;
        logic              carry;
    } alu_res_t;

endpackage
`default_nettype wire

// File: rtl/alu_result_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_result_stage_if                                                 |
// | Unit result buses in, buffered result out, valid/ready both sides.  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface alu_result_stage_if;
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        op_sel;
    logic [DATA_W-1:0] and_res;
    logic [DATA_W-1:0] or_res;
    logic [DATA_W-1:0] xor_res;
    logic [DATA_W-1:0] sum_res;
    logic              sum_cout;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_op;
    logic              out_zero;
    logic              out_carry;

    modport master (
        output in_valid, op_sel, and_res, or_res, xor_res, sum_res, sum_cout, out_ready,
        input  in_ready, out_valid, out_data, out_op, out_zero, out_carry
    );

    modport slave (
        input  in_valid, op_sel, and_res, or_res, xor_res, sum_res, sum_cout, out_ready,
        output in_ready, out_valid, out_data, out_op, out_zero, out_carry
    );

endinterface
`default_nettype wire

// File: rtl/alu_res_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_res_fifo                                                        |
// | DEPTH-entry FIFO with registered push_ready (no ready feed-through).|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module alu_res_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    input  logic             pop_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             push;
    logic             pop;

    assign push       = push_valid & in_ready_q;
    assign pop        = pop_valid & pop_ready;
    assign pop_valid  = (count_q != '0);
    assign pop_data   = mem_q[rd_ptr_q];
    assign push_ready = in_ready_q;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        in_ready_d = (count_d < FULL_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_result_stage                                                    |
// | Opcode mux, zero/carry flags, 2-entry result buffer, pop counter.   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_result_stage_if.slave    bus,
    output logic [CNT_W-1:0]     done_cnt
);

    localparam logic [CNT_W-1:0] DONE_ONE = CNT_W'(1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("alu_result_stage: DEPTH must be a power of two and at least 2");
    end

    alu_res_t                      sel_res;
    alu_res_t                      head_res;
    logic [$bits(alu_res_t)-1:0]   head_bits;
    logic [DATA_W-1:0]             sel_data;
    logic                          head_valid;
    logic                          pop;
    logic [CNT_W-1:0]              done_cnt_q, done_cnt_d;

    // Flags are frozen into the entry at push time, not recomputed at the head.
    always_comb begin
        case (bus.op_sel)
            OP_AND:  sel_data = bus.and_res;
            OP_OR:   sel_data = bus.or_res;
            OP_XOR:  sel_data = bus.xor_res;
            default: sel_data = bus.sum_res;
        endcase
        sel_res.op    = bus.op_sel;
        sel_res.data  = sel_data;
        sel_res.zero  = (sel_data == '0);
        sel_res.carry = (bus.op_sel == OP_ADD) & bus.sum_cout;
    end

    alu_res_fifo #(
        .WIDTH (($bits(alu_res_t))),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (bus.in_valid),
        .push_data  (sel_res),
        .push_ready (bus.in_ready),
        .pop_ready  (bus.out_ready),
        .pop_valid  (head_valid),
        .pop_data   (head_bits)
    );

    assign head_res      = alu_res_t'(head_bits);
    assign bus.out_valid = head_valid;
    assign pop           = head_valid & bus.out_ready;

    always_comb begin
        bus.out_data  = '0;
        bus.out_op    = '0;
        bus.out_zero  = 1'b0;
        bus.out_carry = 1'b0;
        if (head_valid) begin
            bus.out_data  = head_res.data;
            bus.out_op    = head_res.op;
            bus.out_zero  = head_res.zero;
            bus.out_carry = head_res.carry;
        end
    end

    always_comb begin
        done_cnt_d = done_cnt_q;
        if (pop) begin
            done_cnt_d = done_cnt_q + DONE_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_q <= '0;
        end else begin
            done_cnt_q <= done_cnt_d;
        end
    end

    assign done_cnt = done_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_result_stage                                                 |
// | Vector table plus queue scoreboard for the ALU result stage.        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_alu_result_stage;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] done_cnt;

    always #5 clk = ~clk;

    alu_result_stage_if bus ();

    alu_result_stage #(.DEPTH(2), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .done_cnt (done_cnt)
    );

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] o;
        logic [3:0] x;
        logic [3:0] s;
        logic       c;
        logic [3:0] exp_data;
        logic       exp_zero;
        logic       exp_carry;
    } vec_t;

    int       checks = 0;
    int       errors = 0;
    int       n_pops = 0;
    int       stalls = 0;
    bit       track_stall = 1'b0;
    alu_res_t exp_q [$];
    alu_res_t mon_e;
    vec_t     vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic alu_res_t model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] o,
                                       input logic [3:0] x, input logic [3:0] s, input logic c);
        alu_res_t r;
        r.op    = op;
        r.data  = (op == 2'b00) ? a : (op == 2'b01) ? o : (op == 2'b10) ? x : s;
        r.zero  = (r.data == 4'd0);
        r.carry = (op == 2'b11) && c;
        return r;
    endfunction

    // Scoreboard: pops compared before this cycle's push is queued.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_pop: got data %0h with nothing expected", bus.out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_data",  32'(bus.out_data),  32'(mon_e.data));
                    check("sb_op",    32'(bus.out_op),    32'(mon_e.op));
                    check("sb_zero",  32'(bus.out_zero),  32'(mon_e.zero));
                    check("sb_carry", 32'(bus.out_carry), 32'(mon_e.carry));
                end
                n_pops++;
            end
            if (track_stall && !bus.out_valid) stalls++;
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.op_sel, bus.and_res, bus.or_res, bus.xor_res,
                                      bus.sum_res, bus.sum_cout));
        end
    end

    task automatic drive(input logic [1:0] op, input logic [3:0] a, input logic [3:0] o,
                         input logic [3:0] x, input logic [3:0] s, input logic c);
        bus.op_sel   = op;
        bus.and_res  = a;
        bus.or_res   = o;
        bus.xor_res  = x;
        bus.sum_res  = s;
        bus.sum_cout = c;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("in_ready_before_first_edge", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 check("in_ready_after_first_edge", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

        //                op     and    or     xor    sum    cout  data   z     c
        vecs[0] = '{2'b00, 4'hA, 4'hF, 4'h5, 4'h3, 1'b1, 4'hA, 1'b0, 1'b0};
        vecs[1] = '{2'b11, 4'h7, 4'h7, 4'h7, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1};
        vecs[2] = '{2'b10, 4'h9, 4'hC, 4'h0, 4'h6, 1'b1, 4'h0, 1'b1, 1'b0};
        vecs[3] = '{2'b01, 4'h1, 4'h6, 4'h2, 4'h8, 1'b1, 4'h6, 1'b0, 1'b0};
        vecs[4] = '{2'b11, 4'h3, 4'h4, 4'h5, 4'h9, 1'b0, 4'h9, 1'b0, 1'b0};
        vecs[5] = '{2'b11, 4'h0, 4'h0, 4'h0, 4'h7, 1'b1, 4'h7, 1'b0, 1'b1};
        vecs[6] = '{2'b00, 4'h0, 4'hE, 4'hD, 4'hB, 1'b1, 4'h0, 1'b1, 1'b0};
        vecs[7] = '{2'b10, 4'h2, 4'h3, 4'hF, 4'h1, 1'b0, 4'hF, 1'b0, 1'b0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_done_cnt",  32'(done_cnt),      32'd0);
        release_reset();

        // Single-result vectors: latency of one cycle, then popped.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].o, vecs[i].x, vecs[i].s, vecs[i].c);
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            check("vec_out_valid", 32'(bus.out_valid), 32'd1);
            check("vec_out_data",  32'(bus.out_data),  32'(vecs[i].exp_data));
            check("vec_out_op",    32'(bus.out_op),    32'(vecs[i].op));
            check("vec_out_zero",  32'(bus.out_zero),  32'(vecs[i].exp_zero));
            check("vec_out_carry", 32'(bus.out_carry), 32'(vecs[i].exp_carry));
            @(posedge clk);
            #1;
            check("vec_drained",  32'(bus.out_valid), 32'd0);
            check("vec_done_cnt", 32'(done_cnt),      32'(i + 1));
        end

        // Fill while stalled, third request ignored, then drain in order.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(2'b01, 4'h8, 4'h1, 4'h4, 4'h2, 1'b1);
        @(posedge clk);
        #1 check("fill1_in_ready", 32'(bus.in_ready), 32'd1);
        bus.or_res = 4'h2;
        @(posedge clk);
        #1 check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_head", 32'(bus.out_data), 32'h1);
        bus.or_res = 4'h3;
        @(posedge clk);
        #1 check("full_ignores_push", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 check("ready_after_pop", 32'(bus.in_ready), 32'd1);
        check("second_head", 32'(bus.out_data), 32'h2);
        @(posedge clk);
        #1 check("drained_valid", 32'(bus.out_valid), 32'd0);
        check("drained_data", 32'(bus.out_data), 32'd0);
        check("drained_done", 32'(done_cnt), 32'd10);
        check("drained_sb", 32'(exp_q.size()), 32'd0);

        // Reset asserted with two entries buffered.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(2'b00, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0);
        @(posedge clk);
        #1 bus.and_res = 4'h6;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("prereset_full", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        n_pops = 0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_data",  32'(bus.out_data),  32'd0);
        check("async_rst_ready", 32'(bus.in_ready),  32'd0);
        check("async_rst_done",  32'(done_cnt),      32'd0);
        bus.out_ready = 1'b1;
        release_reset();
        repeat (3) @(posedge clk);
        #1;
        check("no_stale_valid", 32'(bus.out_valid), 32'd0);
        check("no_stale_pops",  32'(n_pops),        32'd0);

        // Sustained traffic: 300 results back to back, counter wraps.
        bus.in_valid = 1'b1;
        drive(2'($urandom_range(3)), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) track_stall = 1'b1;
            if (i == 255) check("wrap_done_cnt", 32'(done_cnt), 32'd255);
            if (i == 256) check("wrapped_done_cnt", 32'(done_cnt), 32'd0);
            drive(2'($urandom_range(3)), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 track_stall = 1'b0;
        check("stream_stalls",   32'(stalls),       32'd0);
        check("stream_pops",     32'(n_pops),       32'd300);
        check("stream_done_cnt", 32'(done_cnt),     32'd44);
        check("stream_empty",    32'(bus.out_valid), 32'd0);
        check("stream_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
